// File: rtl/imem_dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_dmem_arbiter_if
// Signal bundle between the RV32IC core (fetch + MEM stage), the shared
// single-port synchronous RAM, and imem_dmem_arbiter.
//
// Signal summary:
//   if_req/if_addr        fetch request and halfword-aligned PC
//   if_rdata/if_ready     assembled instruction and its one-cycle done pulse
//   dm_req/dm_we/dm_be    data request, store select, store byte enables
//   dm_addr/dm_wdata      data byte address and store data
//   dm_rdata/dm_ready     load word (0 for stores) and one-cycle done pulse
//   mem_en/mem_we/mem_be  RAM strobe, write enable, byte enables
//   mem_addr/mem_wdata    RAM word-aligned byte address and write data
//   mem_rdata             RAM read data, valid the cycle after mem_en
//   pc_stall              fetch stall into the hazard unit
//
// Modports:
//   slave  - the arbiter side
//   master - core requesters plus RAM (testbench / surrounding logic)
// -----------------------------------------------------------------------------
interface imem_dmem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;

  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;

  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        pc_stall;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_rdata, if_ready,
    output dm_rdata, dm_ready,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output pc_stall
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_rdata, if_ready,
    input  dm_rdata, dm_ready,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  pc_stall
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_dmem_arbiter
// Shares one single-port synchronous RAM (1-cycle read latency, write commits
// on the issue edge) between the RV32IC fetch stage and the MEM stage.
// Data accesses win arbitration, except that after STARVE_LIMIT consecutive
// data grants with a fetch pending the fetch is forced through. Instructions
// at a halfword-aligned PC whose 32-bit encoding straddles a word boundary are
// assembled from two RAM reads.
//
// Ports:
//   clk     in   clock, all state on rising edge
//   reset   in   synchronous, active-high; abandons any transaction
//   io_bus  slave modport of imem_dmem_arbiter_if (fetch, data, RAM, stall)
//
// Parameters:
//   STARVE_LIMIT  consecutive data grants tolerated while fetch waits (1..15)
//
// State | meaning
//   S_IDLE     | arbitrate; issue the winning access this cycle
//   S_D_WAIT   | data read/write returning; dm_ready pulse
//   S_F_WAIT   | first fetch word returning; ready, or issue second word
//   S_F_WAIT2  | second fetch word returning; assemble and ready pulse
// -----------------------------------------------------------------------------
module imem_dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  imem_dmem_arbiter_if.slave   io_bus
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_D_WAIT  = 2'd1,
    S_F_WAIT  = 2'd2,
    S_F_WAIT2 = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  w_starve_nxt;
  logic [31:0] r_addr_q;
  logic [31:0] w_addr_nxt;
  logic [15:0] r_hold_q;
  logic [15:0] w_hold_nxt;

  logic        w_starved;
  logic        w_data_win;
  logic        w_fetch_win;
  logic        w_straddle;
  logic [31:0] w_fetch_base;

  logic        w_mem_en;
  logic        w_mem_we;
  logic [3:0]  w_mem_be;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic [31:0] w_if_rdata;
  logic        w_if_ready;
  logic [31:0] w_dm_rdata;
  logic        w_dm_ready;

  // Fetch has waited long enough: it takes this arbitration over data.
  assign w_starved    = io_bus.if_req && (r_starve_cnt == LP_LIMIT);
  assign w_data_win   = io_bus.dm_req && !w_starved;
  assign w_fetch_win  = !w_data_win && io_bus.if_req;

  // Upper halfword of the first word is the low half of a 32-bit encoding
  // (opcode bits [1:0] == 2'b11) that continues into the next word.
  assign w_straddle   = (io_bus.mem_rdata[17:16] == 2'b11);
  assign w_fetch_base = {r_addr_q[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= 4'd0;
      r_addr_q     <= 32'd0;
      r_hold_q     <= 16'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_addr_q     <= w_addr_nxt;
      r_hold_q     <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    w_addr_nxt   = r_addr_q;
    w_hold_nxt   = r_hold_q;
    w_mem_en     = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_be     = 4'h0;
    w_mem_addr   = 32'd0;
    w_mem_wdata  = 32'd0;
    w_if_rdata   = 32'd0;
    w_if_ready   = 1'b0;
    w_dm_rdata   = 32'd0;
    w_dm_ready   = 1'b0;

    // Outputs stay at zero while reset is high so a store presented on the
    // reset edge never reaches the RAM.
    if (!reset) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_data_win) begin
            w_mem_en    = 1'b1;
            w_mem_we    = io_bus.dm_we;
            w_mem_be    = io_bus.dm_we ? io_bus.dm_be : 4'hF;
            w_mem_addr  = {io_bus.dm_addr[31:2], 2'b00};
            w_mem_wdata = io_bus.dm_wdata;
            w_state_nxt = S_D_WAIT;
            if (io_bus.if_req && (r_starve_cnt < LP_LIMIT)) begin
              w_starve_nxt = r_starve_cnt + 4'd1;
            end
          end else if (w_fetch_win) begin
            w_mem_en     = 1'b1;
            w_mem_we     = 1'b0;
            w_mem_be     = 4'hF;
            w_mem_addr   = {io_bus.if_addr[31:2], 2'b00};
            w_addr_nxt   = io_bus.if_addr;
            w_starve_nxt = 4'd0;
            w_state_nxt  = S_F_WAIT;
          end
        end

        S_D_WAIT: begin
          w_dm_ready  = 1'b1;
          w_dm_rdata  = io_bus.dm_we ? 32'd0 : io_bus.mem_rdata;
          w_state_nxt = S_IDLE;
        end

        S_F_WAIT: begin
          if (!r_addr_q[1]) begin
            w_if_ready  = 1'b1;
            w_if_rdata  = io_bus.mem_rdata;
            w_state_nxt = S_IDLE;
          end else if (!w_straddle) begin
            w_if_ready  = 1'b1;
            w_if_rdata  = {16'h0000, io_bus.mem_rdata[31:16]};
            w_state_nxt = S_IDLE;
          end else begin
            // Keep the low half, read the next word; address wraps at 2^32.
            w_hold_nxt  = io_bus.mem_rdata[31:16];
            w_mem_en    = 1'b1;
            w_mem_we    = 1'b0;
            w_mem_be    = 4'hF;
            w_mem_addr  = w_fetch_base + 32'd4;
            w_state_nxt = S_F_WAIT2;
          end
        end

        S_F_WAIT2: begin
          w_if_ready  = 1'b1;
          w_if_rdata  = {io_bus.mem_rdata[15:0], r_hold_q};
          w_state_nxt = S_IDLE;
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.mem_en    = w_mem_en;
  assign io_bus.mem_we    = w_mem_we;
  assign io_bus.mem_be    = w_mem_be;
  assign io_bus.mem_addr  = w_mem_addr;
  assign io_bus.mem_wdata = w_mem_wdata;
  assign io_bus.if_rdata  = w_if_rdata;
  assign io_bus.if_ready  = w_if_ready;
  assign io_bus.dm_rdata  = w_dm_rdata;
  assign io_bus.dm_ready  = w_dm_ready;
  assign io_bus.pc_stall  = io_bus.if_req && !w_if_ready && !reset;

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
Shares one single-port synchronous RAM between the RV32IC fetch stage and the MEM stage of the pipelined core.
- Data accesses take priority over fetch, with a starvation counter that guarantees fetch progress.
- Assembles 32-bit instructions that straddle a word boundary (RVC halfword-aligned PC).
- Drives the fetch stall (PCstall) into the hazard logic.

Parameters:
STARVE_LIMIT, 4, consecutive data grants while fetch is pending before fetch is forced to win the next arbitration (1..15).

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
if_req  in  1  fetch request; held with if_addr stable until if_ready
if_addr  in  32  fetch PC, halfword aligned (bit0 ignored)
if_rdata  out  32  instruction; upper 16 bits zero when compressed
if_ready  out  1  one-cycle pulse: if_rdata valid, fetch done
dm_req  in  1  data request; held with controls stable until dm_ready
dm_we  in  1  1=store, 0=load
dm_be  in  4  byte enables for store
dm_addr  in  32  data byte address (word used = dm_addr[31:2])
dm_wdata  in  32  store data
dm_rdata  out  32  load word; 0 for stores
dm_ready  out  1  one-cycle pulse: access complete
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_be  out  4  RAM byte enables (4'b1111 on reads)
mem_addr  out  32  RAM word-aligned byte address, bits[1:0]=00
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid the cycle after mem_en
pc_stall  out  1  if_req & ~if_ready; 0 while reset

Behaviour:
- RAM contract: 1-cycle read latency; a write commits on the issue edge.
- States: IDLE, D_WAIT, F_WAIT, F_WAIT2. Arbitration happens only in IDLE.
- Reset (synchronous):
  - state=IDLE, starve_cnt=0, addr_q=0, hold_q=0.
  - All outputs 0, including mem_en and pc_stall.
  - Reset mid-transaction abandons it with no ready pulse.
  - A write issued on the reset edge itself is not issued (mem_en forced 0).
- IDLE grant rule: data wins if dm_req & !(if_req & starve_cnt==STARVE_LIMIT). Otherwise fetch wins if if_req. Otherwise mem_en=0.
- Data grant (IDLE, combinational):
  - Drives mem_en=1, mem_we=dm_we, mem_be=dm_we?dm_be:4'hF, mem_addr={dm_addr[31:2],2'b00}, mem_wdata=dm_wdata.
  - Next state D_WAIT.
  - starve_cnt increments if if_req, saturating at STARVE_LIMIT.
- D_WAIT: dm_ready=1, dm_rdata = dm_we?0:mem_rdata, then IDLE. Latency issue→ready = 1 cycle.
- Fetch grant (IDLE):
  - Drives mem_en=1, mem_we=0, mem_be=4'hF, mem_addr={if_addr[31:2],2'b00}.
  - Latches addr_q=if_addr, starve_cnt=0, next state F_WAIT.
- F_WAIT:
  - addr_q[1]==0: if_ready=1, if_rdata=mem_rdata, then IDLE.
  - addr_q[1]==1 and mem_rdata[17:16]!=2'b11 (compressed): if_ready=1, if_rdata={16'h0,mem_rdata[31:16]}, then IDLE.
  - addr_q[1]==1 and mem_rdata[17:16]==2'b11 (straddling 32-bit): hold_q=mem_rdata[31:16]; same cycle drive mem_en=1, mem_we=0, mem_addr={addr_q[31:2],2'b00}+4 (wraps mod 2^32, 0xFFFFFFFC→0x0); next state F_WAIT2. No ready pulse.
- F_WAIT2: if_ready=1, if_rdata={mem_rdata[15:0],hold_q}, then IDLE.
- A split fetch is atomic; dm_req waits until IDLE.
- Outside the listed cycles: mem_en=0, if_ready=0, dm_ready=0. mem_addr/mem_wdata/mem_be are don't-care when mem_en=0 but must not be X.
- Back-to-back: minimum 2 cycles per single-word transaction, 3 for a split fetch. No grant in a ready cycle; the next arbitration is in the following IDLE cycle.
- Requester dropping req before ready is illegal. Behaviour is undefined but must return to IDLE with no hang.
- Simultaneous dm_req and if_req with starve_cnt<STARVE_LIMIT: data granted. After STARVE_LIMIT consecutive data grants with fetch pending, fetch is granted.

Test Plan:
- Aligned fetch: RAM[0x10]=0x00500113, if_req addr 0x10 → mem_en cycle 1, if_ready cycle 2, if_rdata=0x00500113, pc_stall=1 in cycle 1 only.
- Compressed upper half: RAM[0x20]=0x4505_0001, fetch 0x22 → single access, if_rdata=0x00004505, ready after 1 cycle.
- Straddle: RAM[0x30]=0x0113_xxxx, RAM[0x34]=0xxxxx_0050, fetch 0x32 → two mem_en cycles at 0x30 and 0x34, if_rdata=0x00500113 in cycle 3. Wrap check: fetch 0xFFFFFFFE → second access at 0x00000000.
- Store/load: dm store addr 0x60 data 3 be 4'hF → mem_we=1, mem_addr=0x60, dm_ready next cycle, dm_rdata=0. Then load 0x60 → dm_rdata=3.
- Starvation: dm_req and if_req held high continuously with STARVE_LIMIT=4 → grants D,D,D,D,F,D,D,D,D,F…; fetch latency bounded to 10 cycles.
- Reset in F_WAIT2 (straddle in progress) → no if_ready, next cycle all outputs 0, state IDLE. A fresh fetch after reset completes normally.
